// File: rtl/adc_scan_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : adc_scan_arbiter
//  Description : Shared MCP3008 conversion sequencer. Requesters are served
//                round-robin. Each grant runs one 17-pulse SPI frame, and the
//                10-bit result is returned tagged with the requester index.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst          : system clock, asynchronous active-high reset
//    req/req_ch/req_diff : per-requester level request, channel, diff mode
//    grant             : one-hot single-cycle grant (request fields latched)
//    busy              : high from grant until the CS-high hold completes
//    result_valid/data/id : conversion result pulse, value and owner
//    null_err          : sticky flag, null bit read back as 1
//    AD_CLK, CS, DIN   : SPI clock, chip select (active low), command out
//    DOUT              : SPI data in from the ADC (asynchronous)
// ============================================================================
module adc_scan_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CLK_DIV = 4,
    parameter int CS_HIGH = 8,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   req_ch,
    input  logic [NUM_REQ-1:0]     req_diff,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   result_valid,
    output logic [9:0]             result_data,
    output logic [ID_W-1:0]        result_id,
    output logic                   null_err,
    output logic                   AD_CLK,
    output logic                   CS,
    output logic                   DIN,
    input  logic                   DOUT
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int HLD_W = $clog2(CS_HIGH) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARB   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    // Pulse numbers within the frame (counted at each SCLK rising edge)
    localparam logic [4:0] PULSE_NULL  = 5'd7;
    localparam logic [4:0] PULSE_FIRST = 5'd8;
    localparam logic [4:0] PULSE_LAST  = 5'd17;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [4:0]       cmd_q, cmd_d;
    logic             din_q, din_d;
    logic             cs_q, cs_d;
    logic             sclk_q, sclk_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       bit_q, bit_d;
    logic [9:0]       shift_q, shift_d;
    logic [HLD_W-1:0] hold_q, hold_d;
    logic             rv_q, rv_d;
    logic [9:0]       rdata_q, rdata_d;
    logic [ID_W-1:0]  rid_q, rid_d;
    logic             nerr_q, nerr_d;
    logic             sync1_q, sync2_q;

    // ------------------------------------------------------------------
    // Round-robin winner search starting at the pointer
    // ------------------------------------------------------------------
    function automatic int wrap_idx(input int base, input int off);
        return (base + off) % NUM_REQ;
    endfunction

    logic            w_found;
    logic [ID_W-1:0] w_win;
    logic [2:0]      w_ch;
    logic            w_sgl;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_ch    = '0;
        w_sgl   = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[wrap_idx(int'(ptr_q), k)]) begin
                w_found = 1'b1;
                w_win   = ID_W'(wrap_idx(int'(ptr_q), k));
                w_ch    = req_ch[3*wrap_idx(int'(ptr_q), k) +: 3];
                w_sgl   = ~req_diff[wrap_idx(int'(ptr_q), k)];
            end
        end
    end

    // ------------------------------------------------------------------
    // SPI timing helpers
    // ------------------------------------------------------------------
    logic       w_tick;
    logic       w_capture;
    logic [9:0] w_shift_next;

    assign w_tick = (div_q == DIV_W'(CLK_DIV - 1));

    // Sample the synchronised DOUT in the first high cycle of each pulse.
    // The two-flop delay means sync2 then reflects DOUT as it stood two
    // cycles earlier, which is still inside the stable window since the
    // ADC only updates DOUT on the falling edge.
    assign w_capture = (state_q == S_SHIFT) && sclk_q && (div_q == '0);

    // Merged path so the last data bit can land in the result on the same
    // edge it is sampled (matters when CLK_DIV is 1).
    assign w_shift_next = (w_capture && (bit_q >= PULSE_FIRST))
                        ? {shift_q[8:0], sync2_q} : shift_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cmd_d   = cmd_q;
        din_d   = din_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        rv_d    = 1'b0;
        rdata_d = rdata_q;
        rid_d   = rid_q;
        nerr_d  = nerr_q;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_ARB;
                end
            end

            S_ARB: begin
                if (w_found) begin
                    ptr_d   = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);
                    id_d    = w_win;
                    // Start bit goes out immediately; remaining command bits
                    // queue behind it in cmd_q and shift out on falling edges.
                    din_d   = 1'b1;
                    cmd_d   = {w_sgl, w_ch, 1'b0};
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    shift_d = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_SHIFT: begin
                shift_d = w_shift_next;
                if (w_capture && (bit_q == PULSE_NULL) && sync2_q) begin
                    nerr_d = 1'b1;
                end
                if (w_tick) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        bit_d = bit_q + 5'd1;
                    end else begin
                        // Falling edge: advance the command bit. After the
                        // fifth pulse the queue is empty so DIN stays 0.
                        din_d = cmd_q[4];
                        cmd_d = {cmd_q[3:0], 1'b0};
                        if (bit_q == PULSE_LAST) begin
                            din_d   = 1'b0;
                            cs_d    = 1'b1;
                            rv_d    = 1'b1;
                            rdata_d = w_shift_next;
                            rid_d   = id_q;
                            hold_d  = '0;
                            state_d = S_HOLD;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            S_HOLD: begin
                // The result cycle counts as the first CS-high cycle, so the
                // hold spans CS_HIGH further cycles before releasing busy.
                if (hold_q == HLD_W'(CS_HIGH)) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q + HLD_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cmd_q   <= '0;
            din_q   <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            rv_q    <= 1'b0;
            rdata_q <= '0;
            rid_q   <= '0;
            nerr_q  <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cmd_q   <= cmd_d;
            din_q   <= din_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            rv_q    <= rv_d;
            rdata_q <= rdata_d;
            rid_q   <= rid_d;
            nerr_q  <= nerr_d;
            sync1_q <= DOUT;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        grant = '0;
        if ((state_q == S_ARB) && w_found) begin
            grant[w_win] = 1'b1;
        end
    end

    assign busy         = (state_q == S_SHIFT) || (state_q == S_HOLD) ||
                          ((state_q == S_ARB) && w_found);
    assign result_valid = rv_q;
    assign result_data  = rdata_q;
    assign result_id    = rid_q;
    assign null_err     = nerr_q;
    assign AD_CLK       = sclk_q;
    assign CS           = cs_q;
    assign DIN          = din_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_scan_arbiter
//  Description : Directed self-checking bench for adc_scan_arbiter with a
//                behavioural MCP3008 model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_scan_arbiter;

    localparam int NUM_REQ = 4;
    localparam int CLK_DIV = 4;
    localparam int CS_HIGH = 8;
    localparam int LAT     = 34*CLK_DIV + 1;
    localparam int SPACING = LAT + CS_HIGH + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = '0;
    logic [11:0]  req_ch = '0;
    logic [3:0]   req_diff = '0;
    logic [3:0]   grant;
    logic         busy;
    logic         result_valid;
    logic [9:0]   result_data;
    logic [1:0]   result_id;
    logic         null_err;
    logic         AD_CLK;
    logic         CS;
    logic         DIN;
    logic         DOUT = 1'b0;

    adc_scan_arbiter #(
        .NUM_REQ (NUM_REQ),
        .CLK_DIV (CLK_DIV),
        .CS_HIGH (CS_HIGH)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_ch       (req_ch),
        .req_diff     (req_diff),
        .grant        (grant),
        .busy         (busy),
        .result_valid (result_valid),
        .result_data  (result_data),
        .result_id    (result_id),
        .null_err     (null_err),
        .AD_CLK       (AD_CLK),
        .CS           (CS),
        .DIN          (DIN),
        .DOUT         (DOUT)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // ADC model and bus monitor (all sampled on the falling clk edge)
    // ------------------------------------------------------------------
    logic [9:0] adc_data = '0;
    logic       adc_null = 1'b0;
    int         pcnt = 0;
    logic [4:0] din_bits = '0;
    int         rise_cyc = 0, fall_cyc = 0, hi_len = 0, lo_len = 0;
    int         cs_low_total = 0, busy_low_total = 0, vcount = 0;
    logic       cs_prev = 1'b1, sclk_prev = 1'b0;

    always @(negedge clk) begin
        int nxt;
        if (!CS && cs_prev) begin
            pcnt     = 0;
            din_bits = '0;
        end
        if (AD_CLK && !sclk_prev) begin
            pcnt++;
            if (pcnt <= 5) din_bits = {din_bits[3:0], DIN};
            if (pcnt > 1) lo_len = cyc - fall_cyc;
            rise_cyc = cyc;
        end
        if (!AD_CLK && sclk_prev) begin
            hi_len   = cyc - rise_cyc;
            fall_cyc = cyc;
            nxt      = pcnt + 1;
            if (nxt == 7)                    DOUT = adc_null;
            else if (nxt >= 8 && nxt <= 17)  DOUT = adc_data[17-nxt];
            else                             DOUT = 1'b0;
        end
        if (CS) DOUT = 1'b0;
        if (!CS)         cs_low_total++;
        if (!busy)       busy_low_total++;
        if (result_valid) vcount++;
        cs_prev   = CS;
        sclk_prev = AD_CLK;
    end

    // ------------------------------------------------------------------
    // Bounded waits
    // ------------------------------------------------------------------
    task automatic wait_grant(input int limit, output int gidx, output int gcyc);
        gidx = -1;
        gcyc = -1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (grant != '0) begin
                for (int i = 0; i < NUM_REQ; i++) if (grant[i]) gidx = i;
                gcyc = cyc;
                return;
            end
        end
    endtask

    task automatic wait_valid(input int limit, output int vcyc);
        vcyc = -1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (result_valid) begin
                vcyc = cyc;
                return;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(tag, busy, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int g, gc, vc, gprev, s0, b0, v0;

        repeat (3) @(negedge clk);
        chk("rst_cs", CS, 1'b1);
        chk("rst_sclk", AD_CLK, 1'b0);
        chk("rst_din", DIN, 1'b0);
        chk("rst_grant", grant, 4'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", result_valid, 1'b0);
        chk("rst_data", result_data, 10'h0);
        chk("rst_id", result_id, 2'd0);
        chk("rst_nerr", null_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single-ended channel 5 on requester 0
        req_ch[2:0] = 3'd5; req_diff[0] = 1'b0; adc_data = 10'h2A5; adc_null = 1'b0;
        req[0] = 1'b1;
        wait_grant(50, g, gc);
        chk("t1_grant", g, 0);
        chk("t1_busy", busy, 1'b1);
        s0 = cs_low_total;
        @(posedge clk); #1 req[0] = 1'b0;
        wait_valid(300, vc);
        chk("t1_latency", vc - gc, LAT);
        chk("t1_data", result_data, 10'h2A5);
        chk("t1_id", result_id, 2'd0);
        chk("t1_din", din_bits, 5'b11101);
        chk("t1_cs_low", cs_low_total - s0, 136);
        chk("t1_nerr", null_err, 1'b0);
        wait_idle("t1_idle");

        // Round robin with every requester held (pointer restarted by reset)
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        req_ch = 12'o7531; req_diff = '0; adc_data = 10'h0F0;
        req = 4'b1111;
        gprev = 0;
        b0 = busy_low_total;
        for (int k = 0; k < 6; k++) begin
            wait_grant(200, g, gc);
            chk($sformatf("rr_grant%0d", k), g, k % 4);
            if (k > 0) begin
                chk($sformatf("rr_space%0d", k), gc - gprev, SPACING);
                chk($sformatf("rr_busylow%0d", k), busy_low_total - b0, 1);
            end
            b0 = busy_low_total;
            gprev = gc;
        end
        @(posedge clk); #1 req = '0;
        wait_valid(300, vc);
        chk("rr_last_id", result_id, 2'd1);
        wait_idle("rr_idle");

        // Differential channel 3 on requester 2
        req_ch[8:6] = 3'd3; req_diff[2] = 1'b1; adc_data = 10'h155;
        req[2] = 1'b1;
        wait_grant(50, g, gc);
        chk("t3_grant", g, 2);
        @(posedge clk); #1 req[2] = 1'b0;
        wait_valid(300, vc);
        chk("t3_din", din_bits, 5'b10011);
        chk("t3_id", result_id, 2'd2);
        chk("t3_data", result_data, 10'h155);
        wait_idle("t3_idle");

        // Null bit read as 1, then a clean frame: flag must stay set
        req_ch[11:9] = 3'd0; req_diff[3] = 1'b0; adc_data = 10'h3C3; adc_null = 1'b1;
        req[3] = 1'b1;
        wait_grant(50, g, gc);
        chk("t4_grant", g, 3);
        @(posedge clk); #1 req[3] = 1'b0;
        wait_valid(300, vc);
        chk("t4_nerr", null_err, 1'b1);
        chk("t4_data", result_data, 10'h3C3);
        wait_idle("t4_idle");
        adc_null = 1'b0; adc_data = 10'h001; req_ch[2:0] = 3'd5; req_diff[0] = 1'b0;
        req[0] = 1'b1;
        wait_grant(50, g, gc);
        @(posedge clk); #1 req[0] = 1'b0;
        wait_valid(300, vc);
        chk("t4b_nerr", null_err, 1'b1);
        chk("t4b_data", result_data, 10'h001);
        wait_idle("t4b_idle");

        // Short req[1] pulse while busy must not be served
        req[0] = 1'b1;
        wait_grant(50, g, gc);
        chk("t6_grant", g, 0);
        @(posedge clk); #1 req[0] = 1'b0;
        repeat (20) @(negedge clk);
        req[1] = 1'b1;
        @(negedge clk);
        req[1] = 1'b0;
        wait_valid(300, vc);
        chk("t6_hi_len", hi_len, CLK_DIV);
        chk("t6_lo_len", lo_len, CLK_DIV);
        wait_idle("t6_idle");
        wait_grant(40, g, gc);
        chk("t6_no_grant", g, -1);

        // Reset in the middle of the frame at pulse 10
        adc_data = 10'h3FF;
        req[0] = 1'b1;
        wait_grant(50, g, gc);
        chk("t5_grant", g, 0);
        @(posedge clk); #1 req[0] = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (pcnt == 10) break;
        end
        chk("t5_pulse", pcnt, 10);
        v0 = vcount;
        #2 rst = 1'b1;
        #1;
        chk("t5_cs_async", CS, 1'b1);
        chk("t5_sclk_async", AD_CLK, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_no_valid", vcount - v0, 0);
        req = 4'b0011;
        wait_grant(50, g, gc);
        chk("t5_ptr0_grant", g, 0);
        @(posedge clk); #1 req = '0;
        wait_valid(300, vc);
        chk("t5_latency", vc - gc, LAT);
        chk("t5_data", result_data, 10'h3FF);
        chk("t5_id", result_id, 2'd0);
        wait_idle("t5_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_scan_arbiter.md
Name: adc_scan_arbiter

Overview:
- Shared sequencer for the MCP3008 8-channel 10-bit SPI ADC used by the brushless drive (throttle pot, phase/bus current, bus voltage).
- Several requesters each ask for a conversion on a chosen channel. Requests are round-robin arbitrated, one MCP3008 frame is run per grant, and the 10-bit result is returned tagged with the requester ID.
- Replaces ad-hoc per-module bit-banging of AD_CLK/CS/DIN.

Parameters:
- NUM_REQ, 4, number of requesters (2..8). ID_W = clog2(NUM_REQ).
- CLK_DIV, 4, clk cycles per SCLK half-period (>=1).
- CS_HIGH, 8, minimum clk cycles CS is held high between frames (>=1).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- req, input, NUM_REQ, level request per requester; held until its grant pulse.
- req_ch, input, 3*NUM_REQ, channel select per requester; slice i = bits [3i+2:3i].
- req_diff, input, NUM_REQ, 1 = differential mode, 0 = single-ended (SGL bit = ~req_diff[i]).
- grant, output, NUM_REQ, one-hot 1-cycle pulse; req_ch/req_diff of that requester are latched in this cycle.
- busy, output, 1, high from grant cycle until the end of the HOLD state.
- result_valid, output, 1, 1-cycle pulse when a conversion completes.
- result_data, output, 10, conversion result (B9..B0); stable until the next result_valid.
- result_id, output, ID_W, requester index for result_data.
- null_err, output, 1, sticky; set if the null bit is read as 1. Cleared only by rst.
- AD_CLK, output, 1, SPI SCLK to ADC; idles low.
- CS, output, 1, ADC chip select, active low; idles high.
- DIN, output, 1, serial command to ADC.
- DOUT, input, 1, serial data from ADC. Double-flop synchronised; sampling point is defined after the sync delay.

Behaviour:
- Reset values: CS=1, AD_CLK=0, DIN=0, grant=0, busy=0, result_valid=0, result_data=0, result_id=0, null_err=0, round-robin pointer=0, FSM=IDLE.
- States: IDLE -> ARB -> SHIFT -> HOLD -> IDLE.
- IDLE: enter ARB whenever any req bit is high.
- ARB (1 cycle):
  - Winner = first requester with req high, searching from the pointer upward with wrap.
  - Assert grant[winner]; latch {start=1, SGL, D2, D1, D0}; pointer <= winner+1 mod NUM_REQ; busy=1.
  - If req is all-zero in ARB, return to IDLE with no grant.
- SHIFT:
  - CS goes low the cycle after grant (cycle G+1), with DIN = start bit.
  - 17 SCLK pulses. First rising edge at G+1+CLK_DIV. Each pulse is high CLK_DIV cycles, then low CLK_DIV cycles.
  - DIN changes only while SCLK is low. Bit k (start, SGL, D2, D1, D0) is driven before rising edge k = 1..5. DIN=0 after pulse 5.
  - Pulse 6 is the sample period; DOUT is ignored.
  - Pulse 7: DOUT is the null bit. If it reads 1, set null_err.
  - Pulses 8..17: DOUT is captured as B9..B0, MSB first, at each rising edge (sync-compensated).
  - At the falling edge of pulse 17: CS=1, result_valid=1, result_data and result_id updated (same cycle).
  - Latency grant -> result_valid = 34*CLK_DIV+1 cycles (137 at default).
- HOLD: CS high for CS_HIGH cycles, then busy=0 and go to IDLE. A pending request is granted at the earliest in the cycle after busy falls.
- Requests changing while busy have no effect on the frame in flight.
- A requester that drops req before being granted is not served. A requester that keeps req high after its grant is re-arbitrated as a new request.
- Simultaneous requests: strict round-robin, so no requester waits more than NUM_REQ-1 frames.
- rst mid-frame: all outputs return to reset values asynchronously (CS high immediately). No result_valid is issued and the partial data is discarded.
- Counters: bit counter 5 bits (0..17); divider counter width = clog2(CLK_DIV)+1; HOLD counter width = clog2(CS_HIGH)+1.

Test Plan:
- req[0]=1, ch=5, diff=0; ADC model returns 0x2A5 -> DIN bits 1,1,1,0,1; result_data=0x2A5, result_id=0, result_valid exactly 137 cycles after grant[0]; CS low for 136 cycles.
- req=4'b1111 held continuously -> grant order 0,1,2,3,0,1; consecutive grants 137+CS_HIGH+2 cycles apart; busy never falls between frames early.
- req[2]=1, ch=3, diff=1 -> SGL bit 0, DIN bits 1,0,0,1,1; result_id=2.
- ADC model drives null bit=1 -> null_err=1 and stays set across later good frames; result still delivered.
- rst asserted at SCLK pulse 10 -> CS=1 and AD_CLK=0 in the same cycle, no result_valid; a new request after release completes normally with pointer=0.
- req[1] pulsed for 1 cycle while busy with requester 0 -> no grant[1] afterwards; AD_CLK high and low phases each measured as CLK_DIV cycles.
